// File: rtl/plru_repl_ctrl.sv
// Tree-PLRU replacement controller for the set-associative LLC model.
// Serialises HIT / ALLOC / CLEAR requests, owns per-set PLRU bits and returns
// one way index per accepted request over a valid/ready response channel.
// Optional build macro PLRU_REPL_STATS_EN adds saturating event counters.
module plru_repl_ctrl #(
    parameter int unsigned N_WAY = 8,
    parameter int unsigned N_SET = 64,
    localparam int unsigned SET_W = $clog2(N_SET),
    localparam int unsigned WAY_W = $clog2(N_WAY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [SET_W-1:0] req_set,
    input  logic [WAY_W-1:0] req_way,
    input  logic [N_WAY-1:0] req_vmask,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WAY_W-1:0] resp_way,
    output logic             resp_evict,
`ifdef PLRU_REPL_STATS_EN
    output logic [31:0]      stat_hit,
    output logic [31:0]      stat_alloc_fill,
    output logic [31:0]      stat_alloc_evict,
`endif
    output logic             init_done
);

    localparam int unsigned NODES    = N_WAY - 1;
    localparam logic [1:0]  OP_ALLOC = 2'd1;
    localparam logic [1:0]  OP_CLEAR = 2'd2;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    logic [NODES-1:0] plru [N_SET];

    state_t           state_q, state_n;
    logic [SET_W-1:0] sweep_q, sweep_n;
    logic [WAY_W-1:0] resp_way_n;
    logic             resp_evict_n;
    logic             accept;
    logic             tree_we;
    logic [SET_W-1:0] tree_wa;
    logic [NODES-1:0] tree_rd, tree_wd;
    logic [WAY_W-1:0] victim;
    logic             vic_evict;

    // Mark way w as most recently used: each node on its path points at w.
    function automatic logic [NODES-1:0] touch(input logic [NODES-1:0] t,
                                               input logic [WAY_W-1:0] w);
        logic [NODES-1:0] r;
        int unsigned      node;
        r    = t;
        node = 0;
        for (int i = int'(WAY_W) - 1; i >= 0; i--) begin
            r    = (r & ~(NODES'(1) << node)) | (NODES'(w[i]) << node);
            node = 2 * node + 1 + 32'(w[i]);
        end
        return r;
    endfunction

    // Follow the pointers away from recently used ways to the PLRU way.
    function automatic logic [WAY_W-1:0] plru_way(input logic [NODES-1:0] t);
        logic [WAY_W-1:0] v;
        logic [NODES-1:0] sh;
        logic             dir;
        int unsigned      node;
        v    = '0;
        node = 0;
        for (int i = int'(WAY_W) - 1; i >= 0; i--) begin
            sh   = t >> node;
            dir  = ~sh[0];
            v[i] = dir;
            node = 2 * node + 1 + 32'(dir);
        end
        return v;
    endfunction

    // Victim choice: lowest invalid way first, otherwise the tree's PLRU way.
    always_comb begin
        tree_rd   = plru[req_set];
        vic_evict = &req_vmask;
        victim    = plru_way(tree_rd);
        if (!vic_evict) begin
            victim = '0;
            for (int i = int'(N_WAY) - 1; i >= 0; i--) begin
                if (!req_vmask[i]) victim = WAY_W'(i);
            end
        end
    end

    // Next-state, handshake and PLRU write-port control.
    always_comb begin
        state_n      = state_q;
        sweep_n      = sweep_q;
        req_ready    = 1'b0;
        tree_we      = 1'b0;
        tree_wa      = req_set;
        tree_wd      = touch(tree_rd, req_way);
        resp_way_n   = resp_way;
        resp_evict_n = resp_evict;

        case (state_q)
            ST_INIT: begin
                tree_we = 1'b1;
                tree_wa = sweep_q;
                tree_wd = '0;
                sweep_n = sweep_q + SET_W'(1);
                if (sweep_q == SET_W'(N_SET - 1)) begin
                    state_n = ST_IDLE;
                    sweep_n = '0;
                end
            end
            ST_IDLE: req_ready = 1'b1;
            ST_RESP: begin
                req_ready = resp_ready;
                if (resp_ready && !req_valid) state_n = ST_IDLE;
            end
            default: state_n = ST_INIT;
        endcase

        if (rst) req_ready = 1'b0;
        accept = req_valid && req_ready;

        if (accept) begin
            state_n = ST_RESP;
            tree_we = 1'b1;
            tree_wa = req_set;
            case (req_op)
                OP_ALLOC: begin
                    tree_wd      = touch(tree_rd, victim);
                    resp_way_n   = victim;
                    resp_evict_n = vic_evict;
                end
                OP_CLEAR: begin
                    tree_wd      = '0;
                    resp_way_n   = '0;
                    resp_evict_n = 1'b0;
                end
                default: begin
                    tree_wd      = touch(tree_rd, req_way);
                    resp_way_n   = req_way;
                    resp_evict_n = 1'b0;
                end
            endcase
        end
    end

    // State and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            sweep_q    <= '0;
            resp_valid <= 1'b0;
            resp_way   <= '0;
            resp_evict <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            state_q    <= state_n;
            sweep_q    <= sweep_n;
            resp_valid <= (state_n == ST_RESP);
            resp_way   <= resp_way_n;
            resp_evict <= resp_evict_n;
            init_done  <= (state_n != ST_INIT);
        end
    end

    // PLRU storage; contents are defined by the INIT sweep, not by reset.
    always_ff @(posedge clk) begin
        if (tree_we) plru[tree_wa] <= tree_wd;
    end

`ifdef PLRU_REPL_STATS_EN
    // Saturating event counters, cleared by reset and during the INIT sweep.
    always_ff @(posedge clk) begin
        if (rst || state_q == ST_INIT) begin
            stat_hit         <= '0;
            stat_alloc_fill  <= '0;
            stat_alloc_evict <= '0;
        end else if (accept) begin
            if (req_op == OP_ALLOC) begin
                if (vic_evict) begin
                    if (stat_alloc_evict != 32'hFFFF_FFFF) stat_alloc_evict <= stat_alloc_evict + 32'd1;
                end else begin
                    if (stat_alloc_fill != 32'hFFFF_FFFF) stat_alloc_fill <= stat_alloc_fill + 32'd1;
                end
            end else if (req_op != OP_CLEAR) begin
                if (stat_hit != 32'hFFFF_FFFF) stat_hit <= stat_hit + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_plru_repl_ctrl.sv
// Directed bench for plru_repl_ctrl (N_WAY=8, N_SET=64).
module tb_plru_repl_ctrl;

    localparam logic [1:0] HIT   = 2'd0;
    localparam logic [1:0] ALLOC = 2'd1;
    localparam logic [1:0] CLEAR = 2'd2;
    localparam logic [1:0] RSVD  = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'd0;
    logic [5:0] req_set = 6'd0;
    logic [2:0] req_way = 3'd0;
    logic [7:0] req_vmask = 8'd0;
    logic       resp_valid;
    logic       resp_ready = 1'b1;
    logic [2:0] resp_way;
    logic       resp_evict;
    logic       init_done;
`ifdef PLRU_REPL_STATS_EN
    logic [31:0] stat_hit, stat_alloc_fill, stat_alloc_evict;
`endif

    int n_checks = 0;
    int n_errors = 0;

    plru_repl_ctrl #(.N_WAY(8), .N_SET(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_set    (req_set),
        .req_way    (req_way),
        .req_vmask  (req_vmask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_way   (resp_way),
        .resp_evict (resp_evict),
`ifdef PLRU_REPL_STATS_EN
        .stat_hit         (stat_hit),
        .stat_alloc_fill  (stat_alloc_fill),
        .stat_alloc_evict (stat_alloc_evict),
`endif
        .init_done  (init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [5:0] set;
        logic [2:0] way;
        logic [7:0] vmask;
        logic [2:0] exp_way;
        logic       exp_evict;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reset for one edge then expect exactly 64 sweep cycles before init_done.
    task automatic run_init();
        logic bad;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        bad = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk);
            #1;
            if (k < 64 && (init_done !== 1'b0 || req_ready !== 1'b0 || resp_valid !== 1'b0)) bad = 1'b1;
        end
        chk("init_busy_window", 32'(bad), 32'd0);
        chk("init_done_at_64", 32'(init_done), 32'd1);
        chk("ready_after_init", 32'(req_ready), 32'd1);
    endtask

    // Present one request (called #1 after an edge), accept it, check response.
    task automatic do_req(input string name, input logic [1:0] op, input logic [5:0] set,
                          input logic [2:0] way, input logic [7:0] vmask,
                          input logic [2:0] exp_way, input logic exp_evict);
        req_valid = 1'b1;
        req_op    = op;
        req_set   = set;
        req_way   = way;
        req_vmask = vmask;
        #1;
        chk({name, "_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        chk({name, "_valid"}, 32'(resp_valid), 32'd1);
        chk({name, "_way"}, 32'(resp_way), 32'(exp_way));
        chk({name, "_evict"}, 32'(resp_evict), 32'(exp_evict));
    endtask

    initial begin
        vecs[0]  = '{ALLOC, 6'd5,  3'd0, 8'hFF, 3'd7, 1'b1};
        vecs[1]  = '{ALLOC, 6'd5,  3'd0, 8'hFF, 3'd3, 1'b1};
        vecs[2]  = '{HIT,   6'd3,  3'd7, 8'h00, 3'd7, 1'b0};
        vecs[3]  = '{ALLOC, 6'd3,  3'd0, 8'hFF, 3'd3, 1'b1};
        vecs[4]  = '{ALLOC, 6'd9,  3'd0, 8'hFB, 3'd2, 1'b0};
        vecs[5]  = '{ALLOC, 6'd9,  3'd0, 8'hFF, 3'd7, 1'b1};
        vecs[6]  = '{ALLOC, 6'd9,  3'd0, 8'hFF, 3'd1, 1'b1};
        vecs[7]  = '{CLEAR, 6'd5,  3'd3, 8'h00, 3'd0, 1'b0};
        vecs[8]  = '{ALLOC, 6'd5,  3'd0, 8'hFF, 3'd7, 1'b1};
        vecs[9]  = '{HIT,   6'd63, 3'd5, 8'h00, 3'd5, 1'b0};
        vecs[10] = '{ALLOC, 6'd63, 3'd0, 8'hFF, 3'd3, 1'b1};
        vecs[11] = '{ALLOC, 6'd0,  3'd0, 8'h00, 3'd0, 1'b0};
        vecs[12] = '{ALLOC, 6'd0,  3'd0, 8'h7F, 3'd7, 1'b0};
        vecs[13] = '{RSVD,  6'd1,  3'd6, 8'h00, 3'd6, 1'b0};
        vecs[14] = '{CLEAR, 6'd63, 3'd5, 8'hFF, 3'd0, 1'b0};
        vecs[15] = '{ALLOC, 6'd63, 3'd0, 8'hFF, 3'd7, 1'b1};

        run_init();

        // Back-to-back table run with a never-stalling consumer.
        for (int i = 0; i < 16; i++) begin
            do_req($sformatf("vec%0d", i), vecs[i].op, vecs[i].set, vecs[i].way,
                   vecs[i].vmask, vecs[i].exp_way, vecs[i].exp_evict);
        end
        req_valid = 1'b0;

        // Consumer stall: response must hold while an ALLOC waits.
        do_req("stall_hit", HIT, 6'd10, 3'd4, 8'h00, 3'd4, 1'b0);
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_op     = ALLOC;
        req_set    = 6'd10;
        req_vmask  = 8'hFF;
        #1;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("stall%0d_valid", c), 32'(resp_valid), 32'd1);
            chk($sformatf("stall%0d_way", c), 32'(resp_way), 32'd4);
            chk($sformatf("stall%0d_ready", c), 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        resp_ready = 1'b1;
        #1;
        chk("release_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("queued_alloc_valid", 32'(resp_valid), 32'd1);
        chk("queued_alloc_way", 32'(resp_way), 32'd3);
        chk("queued_alloc_evict", 32'(resp_evict), 32'd1);

`ifdef PLRU_REPL_STATS_EN
        chk("stat_hit", stat_hit, 32'd4);
        chk("stat_alloc_fill", stat_alloc_fill, 32'd3);
        chk("stat_alloc_evict", stat_alloc_evict, 32'd9);
`endif

        // Reset while a response is pending: discard it and restart the sweep.
        resp_ready = 1'b0;
        chk("pre_rst_resp_valid", 32'(resp_valid), 32'd1);
        run_init();
        resp_ready = 1'b1;
`ifdef PLRU_REPL_STATS_EN
        chk("stat_hit_cleared", stat_hit, 32'd0);
        chk("stat_evict_cleared", stat_alloc_evict, 32'd0);
`endif
        do_req("post_rst_alloc", ALLOC, 6'd5, 3'd0, 8'hFF, 3'd7, 1'b1);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_no_resp", 32'(resp_valid), 32'd0);
        chk("idle_ready", 32'(req_ready), 32'd1);
`ifdef PLRU_REPL_STATS_EN
        chk("stat_evict_after", stat_alloc_evict, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
